// File: rtl/store_buffer.sv
// Store buffer between MEM and data memory: a FIFO of committed stores that
// drains whenever no load owns the shared port, and flags same-word loads.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic [2:0]              st_funct3,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [2:0]              ld_funct3,
    output logic                    ld_hazard,
    output logic                    ld_grant,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [2:0]              mem_funct3,
    output logic                    buf_empty,
    output logic [$clog2(DEPTH):0]  buf_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] entry_addr   [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data   [DEPTH];
    logic [2:0]            entry_funct3 [DEPTH];
    logic [DEPTH-1:0]      entry_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             word_hit;

    assign st_ready  = (count != FULL_COUNT);
    assign buf_empty = (count == '0);
    assign buf_count = count;
    assign push      = st_valid && st_ready;

    // Word-granular match against buffered entries only; the store being
    // pushed this cycle is not yet visible here.
    always_comb begin
        word_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                (entry_addr[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid && word_hit;
    assign ld_grant  = ld_valid && !word_hit;
    assign pop       = !ld_grant && !buf_empty;

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_funct3  = 3'b000;
        if (ld_grant) begin
            mem_addr   = ld_addr;
            mem_funct3 = ld_funct3;
        end else if (pop) begin
            mem_wr_en   = 1'b1;
            mem_addr    = entry_addr[head];
            mem_wr_data = entry_data[head];
            mem_funct3  = entry_funct3[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                head              <= head + PTR_W'(1);
                entry_valid[head] <= 1'b0;
            end
            if (push) begin
                tail              <= tail + PTR_W'(1);
                entry_valid[tail] <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail]   <= st_addr;
            entry_data[tail]   <= st_data;
            entry_funct3[tail] <= st_funct3;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a little-endian byte-lane data memory
// model that applies drained stores and serves granted loads.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_hazard;
    logic        ld_grant;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [2:0]  mem_funct3;
    logic        buf_empty;
    logic [2:0]  buf_count;

    logic [31:0] dmem [0:255];
    logic [31:0] rdata;
    int checks = 0;
    int fails  = 0;
    int writes = 0;

    store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_funct3(st_funct3), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_hazard(ld_hazard), .ld_grant(ld_grant),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_funct3(mem_funct3), .buf_empty(buf_empty), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    assign rdata = dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            writes <= writes + 1;
            case (mem_funct3[1:0])
                2'b00:   dmem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wr_data[7:0];
                2'b01:   dmem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_wr_data[15:0];
                default: dmem[mem_addr[9:2]] <= mem_wr_data;
            endcase
        end
    end

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f);
        st_valid = v; st_addr = a; st_data = d; st_funct3 = f;
    endtask

    task automatic drive_ld(input logic v, input logic [31:0] a, input logic [2:0] f);
        ld_valid = v; ld_addr = a; ld_funct3 = f;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        drive_ld(1'b1, 32'h100, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (buf_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", buf_count); end
        checks++; if (buf_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", buf_empty); end
        checks++; if (st_ready !== 1'b1) begin fails++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
        checks++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
        checks++; if ({ld_hazard, ld_grant} !== 2'b01) begin fails++; $display("FAIL reset_ld: got hazard/grant %b expected 01", {ld_hazard, ld_grant}); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_ld(1'b0, 32'h0, 3'b000);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain;
        int w0;
        drive_ld(1'b1, 32'h100, 3'b010);
        drive_st(1'b1, 32'h300, 32'h0000CAFE, 3'b010);
        @(negedge clk);
        drive_st(1'b1, 32'h304, 32'h0000BEEF, 3'b010);
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if (buf_count !== 3'd2) begin fails++; $display("FAIL rmd_count: got %0d expected 2", buf_count); end
        drive_ld(1'b0, 32'h0, 3'b000);
        #1;
        checks++; if ({mem_wr_en, mem_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL rmd_drain: got %b/%h expected 1/00000300", mem_wr_en, mem_addr); end
        w0 = writes;
        rst_n = 1'b0;
        #1;
        checks++; if ({buf_count, buf_empty, mem_wr_en} !== {3'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL rmd_in_reset: got count %0d empty %b wr_en %b expected 0 1 0", buf_count, buf_empty, mem_wr_en); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (writes !== w0) begin fails++; $display("FAIL rmd_no_writes: got %0d writes expected %0d", writes, w0); end
        checks++; if (dmem[8'hC0] !== 32'h0) begin fails++; $display("FAIL rmd_mem: got %h expected 00000000", dmem[8'hC0]); end
    endtask

    task automatic test_drain_order;
        @(negedge clk);
        drive_st(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        #1;
        checks++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL drain_push_latency: got wr_en %b expected 0", mem_wr_en); end
        @(negedge clk);
        drive_st(1'b1, 32'h21, 32'h000000AA, 3'b000);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, mem_funct3} !== {1'b1, 32'h10, 32'hDEADBEEF, 3'b010}) begin fails++; $display("FAIL drain_sw: got %b %h %h %b expected 1 00000010 deadbeef 010", mem_wr_en, mem_addr, mem_wr_data, mem_funct3); end
        @(negedge clk);
        drive_st(1'b1, 32'h32, 32'h00001234, 3'b001);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, mem_funct3} !== {1'b1, 32'h21, 32'hAA, 3'b000}) begin fails++; $display("FAIL drain_sb: got %b %h %h %b expected 1 00000021 000000aa 000", mem_wr_en, mem_addr, mem_wr_data, mem_funct3); end
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, mem_funct3} !== {1'b1, 32'h32, 32'h1234, 3'b001}) begin fails++; $display("FAIL drain_sh: got %b %h %h %b expected 1 00000032 00001234 001", mem_wr_en, mem_addr, mem_wr_data, mem_funct3); end
        @(negedge clk);
        #1;
        checks++; if ({mem_wr_en, buf_empty} !== 2'b01) begin fails++; $display("FAIL drain_idle: got wr_en/empty %b expected 01", {mem_wr_en, buf_empty}); end
        drive_ld(1'b1, 32'h10, 3'b010);
        #1;
        checks++; if ({ld_grant, rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL drain_rd_word: got %b %h expected 1 deadbeef", ld_grant, rdata); end
        drive_ld(1'b1, 32'h20, 3'b010);
        #1;
        checks++; if (rdata[15:8] !== 8'hAA) begin fails++; $display("FAIL drain_rd_byte: got %h expected aa", rdata[15:8]); end
        // sh at 0x32 lands in bytes 2..3 of the word at 0x30
        drive_ld(1'b1, 32'h30, 3'b010);
        #1;
        checks++; if (rdata[31:16] !== 16'h1234) begin fails++; $display("FAIL drain_rd_half: got %h expected 1234", rdata[31:16]); end
        drive_ld(1'b0, 32'h0, 3'b000);
    endtask

    task automatic test_full_wrap;
        @(negedge clk);
        drive_ld(1'b1, 32'h100, 3'b010);
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'h200 + 32'(4 * i), 32'h11 * 32'(i + 1), 3'b010);
            #1;
            checks++; if ({ld_grant, mem_wr_en, mem_addr, st_ready} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin fails++; $display("FAIL fill_%0d: got grant %b wr_en %b addr %h ready %b expected 1 0 00000100 1", i, ld_grant, mem_wr_en, mem_addr, st_ready); end
            @(negedge clk);
        end
        drive_st(1'b1, 32'h210, 32'h55, 3'b010);
        #1;
        checks++; if ({buf_count, st_ready} !== {3'd4, 1'b0}) begin fails++; $display("FAIL full_ready: got count %0d ready %b expected 4 0", buf_count, st_ready); end
        @(negedge clk);
        #1;
        checks++; if ({buf_count, ld_grant, mem_wr_en} !== {3'd4, 1'b1, 1'b0}) begin fails++; $display("FAIL full_ignored: got count %0d grant %b wr_en %b expected 4 1 0", buf_count, ld_grant, mem_wr_en); end
        drive_ld(1'b0, 32'h0, 3'b000);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, st_ready, buf_count} !== {1'b1, 32'h200, 32'h11, 1'b0, 3'd4}) begin fails++; $display("FAIL wrap_pop0: got %b %h %h ready %b count %0d expected 1 00000200 00000011 0 4", mem_wr_en, mem_addr, mem_wr_data, st_ready, buf_count); end
        @(negedge clk);
        #1;
        checks++; if ({mem_addr, mem_wr_data, st_ready, buf_count} !== {32'h204, 32'h22, 1'b1, 3'd3}) begin fails++; $display("FAIL wrap_pop1: got %h %h ready %b count %0d expected 00000204 00000022 1 3", mem_addr, mem_wr_data, st_ready, buf_count); end
        @(negedge clk);
        drive_st(1'b1, 32'h214, 32'h66, 3'b010);
        #1;
        checks++; if ({mem_addr, mem_wr_data, buf_count} !== {32'h208, 32'h33, 3'd3}) begin fails++; $display("FAIL wrap_pop2: got %h %h count %0d expected 00000208 00000033 3", mem_addr, mem_wr_data, buf_count); end
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if ({mem_addr, mem_wr_data, buf_count} !== {32'h20C, 32'h44, 3'd3}) begin fails++; $display("FAIL wrap_pop3: got %h %h count %0d expected 0000020c 00000044 3", mem_addr, mem_wr_data, buf_count); end
        @(negedge clk);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, buf_count} !== {1'b1, 32'h210, 32'h55, 3'd2}) begin fails++; $display("FAIL wrap_pop4: got %b %h %h count %0d expected 1 00000210 00000055 2", mem_wr_en, mem_addr, mem_wr_data, buf_count); end
        @(negedge clk);
        #1;
        checks++; if ({mem_wr_en, mem_addr, mem_wr_data, buf_count} !== {1'b1, 32'h214, 32'h66, 3'd1}) begin fails++; $display("FAIL wrap_pop5: got %b %h %h count %0d expected 1 00000214 00000066 1", mem_wr_en, mem_addr, mem_wr_data, buf_count); end
        @(negedge clk);
        #1;
        checks++; if ({mem_wr_en, buf_empty} !== 2'b01) begin fails++; $display("FAIL wrap_empty: got wr_en/empty %b expected 01", {mem_wr_en, buf_empty}); end
    endtask

    task automatic test_hazard;
        @(negedge clk);
        drive_st(1'b1, 32'h40, 32'd5, 3'b010);
        drive_ld(1'b1, 32'h42, 3'b010);
        #1;
        checks++; if ({ld_hazard, ld_grant} !== 2'b01) begin fails++; $display("FAIL hz_same_cycle_push: got hazard/grant %b expected 01", {ld_hazard, ld_grant}); end
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if ({ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 1'b0, 1'b1, 32'h40, 32'd5}) begin fails++; $display("FAIL hz_stall: got %b %b %b %h %h expected 1 0 1 00000040 00000005", ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data); end
        @(negedge clk);
        #1;
        checks++; if ({ld_hazard, ld_grant, mem_addr, rdata} !== {1'b0, 1'b1, 32'h42, 32'd5}) begin fails++; $display("FAIL hz_release: got %b %b %h %h expected 0 1 00000042 00000005", ld_hazard, ld_grant, mem_addr, rdata); end
        drive_ld(1'b0, 32'h0, 3'b000);
    endtask

    task automatic test_hazard_two_entries;
        @(negedge clk);
        drive_ld(1'b1, 32'h100, 3'b010);
        drive_st(1'b1, 32'h80, 32'd1, 3'b010);
        @(negedge clk);
        drive_st(1'b1, 32'h80, 32'hFF, 3'b000);
        #1;
        checks++; if ({ld_hazard, ld_grant} !== 2'b01) begin fails++; $display("FAIL hz2_other_word: got hazard/grant %b expected 01", {ld_hazard, ld_grant}); end
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 3'b000);
        drive_ld(1'b1, 32'h80, 3'b010);
        #1;
        checks++; if ({ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data, mem_funct3} !== {1'b1, 1'b0, 1'b1, 32'h80, 32'd1, 3'b010}) begin fails++; $display("FAIL hz2_cycle1: got %b %b %b %h %h %b expected 1 0 1 00000080 00000001 010", ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data, mem_funct3); end
        @(negedge clk);
        #1;
        checks++; if ({ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data, mem_funct3} !== {1'b1, 1'b0, 1'b1, 32'h80, 32'hFF, 3'b000}) begin fails++; $display("FAIL hz2_cycle2: got %b %b %b %h %h %b expected 1 0 1 00000080 000000ff 000", ld_hazard, ld_grant, mem_wr_en, mem_addr, mem_wr_data, mem_funct3); end
        @(negedge clk);
        #1;
        checks++; if ({ld_hazard, ld_grant, rdata} !== {1'b0, 1'b1, 32'h000000FF}) begin fails++; $display("FAIL hz2_load: got %b %b %h expected 0 1 000000ff", ld_hazard, ld_grant, rdata); end
        drive_ld(1'b0, 32'h0, 3'b000);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        test_reset;
        test_reset_mid_drain;
        test_drain_order;
        test_full_wrap;
        test_hazard;
        test_hazard_two_entries;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
